// File: rtl/mor1kx_dbus_sram_responder.sv
// Single-port SRAM responder for the mor1kx data bus.
// One access at a time: IDLE -> (WAIT) -> RESP -> RECOVER -> IDLE.
// Optional feature macro: MOR1KX_DBUS_RESP_ERR_EN. When it is defined, invalid accesses
// complete with an error pulse. Otherwise they are acked: reads return 0 and writes are dropped.
module mor1kx_dbus_sram_responder #(
  parameter int unsigned OPTION_OPERAND_WIDTH = 32,
  parameter int unsigned MEM_DEPTH_LOG2       = 8,
  parameter int unsigned WAIT_STATES          = 1,
  parameter logic [OPTION_OPERAND_WIDTH-1:0] BASE_ADR = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [OPTION_OPERAND_WIDTH-1:0] dbus_adr_i,
  input  logic                            dbus_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] dbus_dat_i,
  input  logic [3:0]                      dbus_bsel_i,
  input  logic                            dbus_we_i,
  input  logic                            dbus_burst_i,
  output logic                            dbus_ack_o,
  output logic                            dbus_err_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] dbus_dat_o
);

  localparam int unsigned Depth = 1 << MEM_DEPTH_LOG2;
  localparam logic [3:0] WaitLoad = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp, StRecover} state_e;

  state_e                            state_q, state_d;
  logic [3:0]                        cnt_q, cnt_d;
  logic [OPTION_OPERAND_WIDTH-1:0]   adr_q, adr_d;
  logic [OPTION_OPERAND_WIDTH-1:0]   dat_q, dat_d;
  logic [3:0]                        bsel_q, bsel_d;
  logic                              we_q, we_d;

  logic [OPTION_OPERAND_WIDTH-1:0]   mem_q [Depth];

  logic [OPTION_OPERAND_WIDTH-1:0]   offset;
  logic [MEM_DEPTH_LOG2-1:0]         word_idx;
  logic                              in_range;
  logic                              bsel_ok;
  logic                              valid;
  logic                              mem_we;

  // Every access is a single beat, so the burst hint carries no information.
  logic unused_burst;
  assign unused_burst = dbus_burst_i;

  // Address decode on the captured request. An address below BASE_ADR wraps to a large
  // offset, so a single upper-bits check covers both ends of the window.
  always_comb begin
    offset   = adr_q - BASE_ADR;
    in_range = (offset >> (MEM_DEPTH_LOG2 + 2)) == '0;
    word_idx = offset[MEM_DEPTH_LOG2+1:2];
    case (bsel_q)
      4'b1000, 4'b0100, 4'b0010, 4'b0001,
      4'b1100, 4'b0011, 4'b1111: bsel_ok = 1'b1;
      default:                   bsel_ok = 1'b0;
    endcase
    valid  = in_range & bsel_ok;
    // A reset on the RESP edge aborts the access, so it must also block the write.
    mem_we = rst & (state_q == StResp) & we_q & valid;
  end

  // Next-state logic and request capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    bsel_d  = bsel_q;
    we_d    = we_q;
    unique case (state_q)
      StIdle: begin
        if (dbus_req_i) begin
          adr_d  = dbus_adr_i;
          dat_d  = dbus_dat_i;
          bsel_d = dbus_bsel_i;
          we_d   = dbus_we_i;
          if (WAIT_STATES == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = WaitLoad;
          end
        end
      end
      StWait: begin
        if (!dbus_req_i) begin
          // Initiator abandoned the access: no write, no response.
          state_d = StIdle;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:    state_d = StRecover;
      // req is still high here from the finished access; it must not start a new one.
      StRecover: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Response outputs, decoded from the state so they are zero outside RESP.
  always_comb begin
    dbus_ack_o = 1'b0;
    dbus_err_o = 1'b0;
    dbus_dat_o = '0;
    if (state_q == StResp) begin
`ifdef MOR1KX_DBUS_RESP_ERR_EN
      dbus_ack_o = valid;
      dbus_err_o = ~valid;
`else
      dbus_ack_o = 1'b1;
`endif
      if (valid && !we_q) begin
        dbus_dat_o = mem_q[word_idx];
      end
    end
  end

  // FSM and captured-request registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      adr_q   <= '0;
      dat_q   <= '0;
      bsel_q  <= 4'd0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      bsel_q  <= bsel_d;
      we_q    <= we_d;
    end
  end

  // Byte-lane writes into the backing array; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bsel_q[b]) begin
          mem_q[word_idx][8*b +: 8] <= dat_q[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mor1kx_dbus_sram_responder.sv
// Directed bench for mor1kx_dbus_sram_responder with three instances that differ only in
// WAIT_STATES (1, 3, 0). Expected responses are pushed to a scoreboard when a request is
// driven and popped when the responder answers.
module tb_mor1kx_dbus_sram_responder;

  logic        clk;
  logic        rst;
  logic        rq    [3];
  logic        we    [3];
  logic        burst [3];
  logic        ack   [3];
  logic        err   [3];
  logic [31:0] adr   [3];
  logic [31:0] wdat  [3];
  logic [31:0] rdat  [3];
  logic [3:0]  bsel  [3];

  logic [31:0] model [3][256];

  typedef struct {
    logic        ack;
    logic        err;
    logic [31:0] dat;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mor1kx_dbus_sram_responder #(.WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst(rst), .dbus_adr_i(adr[0]), .dbus_req_i(rq[0]), .dbus_dat_i(wdat[0]),
    .dbus_bsel_i(bsel[0]), .dbus_we_i(we[0]), .dbus_burst_i(burst[0]),
    .dbus_ack_o(ack[0]), .dbus_err_o(err[0]), .dbus_dat_o(rdat[0])
  );
  mor1kx_dbus_sram_responder #(.WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst), .dbus_adr_i(adr[1]), .dbus_req_i(rq[1]), .dbus_dat_i(wdat[1]),
    .dbus_bsel_i(bsel[1]), .dbus_we_i(we[1]), .dbus_burst_i(burst[1]),
    .dbus_ack_o(ack[1]), .dbus_err_o(err[1]), .dbus_dat_o(rdat[1])
  );
  mor1kx_dbus_sram_responder #(.WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .dbus_adr_i(adr[2]), .dbus_req_i(rq[2]), .dbus_dat_i(wdat[2]),
    .dbus_bsel_i(bsel[2]), .dbus_we_i(we[2]), .dbus_burst_i(burst[2]),
    .dbus_ack_o(ack[2]), .dbus_err_o(err[2]), .dbus_dat_o(rdat[2])
  );

  function automatic int ws_of(input int i);
    case (i)
      0:       return 1;
      1:       return 3;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete access on instance i, entered and left on a negedge with the FSM idle.
  task automatic access(input int i, input logic [31:0] a, input logic w, input logic [3:0] bs,
                        input logic [31:0] d, input string tag);
    exp_t e;
    exp_t got;
    logic ok;
    int   cyc;
    ok = (a < 32'h400) && (bs inside {4'b1000, 4'b0100, 4'b0010, 4'b0001,
                                      4'b1100, 4'b0011, 4'b1111});
`ifdef MOR1KX_DBUS_RESP_ERR_EN
    e.ack = ok;
    e.err = !ok;
`else
    e.ack = 1'b1;
    e.err = 1'b0;
`endif
    e.dat = (ok && !w) ? model[i][a[9:2]] : 32'h0;
    e.lat = 1 + ws_of(i);
    sb.push_back(e);
    if (ok && w) begin
      for (int b = 0; b < 4; b++) begin
        if (bs[b]) model[i][a[9:2]][8*b +: 8] = d[8*b +: 8];
      end
    end
    adr[i]  = a;
    we[i]   = w;
    bsel[i] = bs;
    wdat[i] = d;
    rq[i]   = 1'b1;
    cyc     = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (ack[i] || err[i]) break;
      check({tag, "_waitdat"}, rdat[i], 32'h0);
    end
    got.ack = ack[i];
    got.err = err[i];
    got.dat = rdat[i];
    got.lat = cyc;
    e = sb.pop_front();
    check({tag, "_lat"}, got.lat, e.lat);
    check({tag, "_ack"}, {31'h0, got.ack}, {31'h0, e.ack});
    check({tag, "_err"}, {31'h0, got.err}, {31'h0, e.err});
    check({tag, "_dat"}, got.dat, e.dat);
    // RECOVER: pulse must be over; the initiator drops req now.
    @(negedge clk);
    check({tag, "_pulse"}, {30'h0, ack[i], err[i]}, 32'h0);
    rq[i] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rq[i] = 1'b0; we[i] = 1'b0; burst[i] = 1'b0;
      adr[i] = '0; wdat[i] = '0; bsel[i] = '0;
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_ack", {31'h0, ack[i]}, 32'h0);
      check("rst_err", {31'h0, err[i]}, 32'h0);
      check("rst_dat", rdat[i], 32'h0);
    end
    rst = 1'b1;
    @(negedge clk);

    // WAIT_STATES=1: full-word write/read, byte and halfword lanes.
    access(0, 32'h10, 1'b1, 4'b1111, 32'hDEADBEEF, "wr10");
    access(0, 32'h10, 1'b0, 4'b1111, 32'h0,        "rd10");
    access(0, 32'h10, 1'b1, 4'b1111, 32'h11223344, "wr10b");
    access(0, 32'h11, 1'b1, 4'b0100, 32'hAAAAAAAA, "wrbyte");
    access(0, 32'h10, 1'b0, 4'b1111, 32'h0,        "rdbyte");
    access(0, 32'h14, 1'b1, 4'b1111, 32'h01234567, "wr14");
    access(0, 32'h16, 1'b1, 4'b0011, 32'h99889988, "wrhalf");
    access(0, 32'h14, 1'b1, 4'b1000, 32'h5A5A5A5A, "wrb3");
    access(0, 32'h14, 1'b0, 4'b1111, 32'h0,        "rd14");
    // Out-of-range read and illegal byte-select write.
    access(0, 32'h400, 1'b0, 4'b1111, 32'h0,        "rd400");
    access(0, 32'h10,  1'b1, 4'b0110, 32'hFFFFFFFF, "wrbad");
    access(0, 32'h10,  1'b0, 4'b1111, 32'h0,        "rdafterbad");

    // Reset during WAIT of a write drops it.
    access(0, 32'h18, 1'b1, 4'b1111, 32'h01020304, "wr18");
    adr[0] = 32'h18; we[0] = 1'b1; bsel[0] = 4'b1111; wdat[0] = 32'hCAFEF00D;
    rq[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ack", {31'h0, ack[0]}, 32'h0);
    check("midrst_err", {31'h0, err[0]}, 32'h0);
    check("midrst_dat", rdat[0], 32'h0);
    rst = 1'b1;
    rq[0] = 1'b0;
    @(negedge clk);
    access(0, 32'h18, 1'b0, 4'b1111, 32'h0, "rd18");
    // Earlier data survives the reset.
    access(0, 32'h10, 1'b0, 4'b1111, 32'h0, "rd10post");

    // WAIT_STATES=3: abort a write after two cycles.
    access(1, 32'h20, 1'b1, 4'b1111, 32'h12345678, "ws3wr");
    adr[1] = 32'h20; we[1] = 1'b1; bsel[1] = 4'b1111; wdat[1] = 32'hFFFF0000;
    rq[1] = 1'b1;
    repeat (2) @(negedge clk);
    rq[1] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("abort_resp", {30'h0, ack[1], err[1]}, 32'h0);
    end
    access(1, 32'h20, 1'b0, 4'b1111, 32'h0, "ws3rd");

    // WAIT_STATES=0: back-to-back reads with req held through RECOVER.
    access(2, 32'h30, 1'b1, 4'b1111, 32'h0F0FA5A5, "ws0wr");
    access(2, 32'h30, 1'b0, 4'b1111, 32'h0,        "ws0rd");
    adr[2] = 32'h30; we[2] = 1'b0; bsel[2] = 4'b1111;
    rq[2] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check("b2b_ack", {31'h0, ack[2]}, {31'h0, (k % 3) == 1});
      check("b2b_dat", rdat[2], ((k % 3) == 1) ? model[2][8'h0C] : 32'h0);
    end
    rq[2] = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
